// File: rtl/arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package arb_pkg;

    localparam int unsigned XLEN = 32;

    // Read data returned when an access is abandoned by the watchdog.
    localparam logic [XLEN-1:0] DROP_DATA_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the memory port arbiter.
interface mem_port_arbiter_if;
    import arb_pkg::*;

    // Fetch side
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_flush;
    logic            if_valid;
    logic [XLEN-1:0] if_rdata;
    logic            stall_f;

    // Data side
    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_valid;
    logic [XLEN-1:0] d_rdata;
    logic            stall_m;

    // Memory side
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            err_timeout;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_valid, if_rdata, stall_f, d_valid, d_rdata, stall_m,
               mem_req, mem_we, mem_addr, mem_wdata, err_timeout
    );

    // Pipeline and memory side
    modport master (
        output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_valid, if_rdata, stall_f, d_valid, d_rdata, stall_m,
               mem_req, mem_we, mem_addr, mem_wdata, err_timeout
    );

endinterface

// File: rtl/arb_watchdog.sv
// Busy-cycle counter for the memory port; flags an access that never got an ack.
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] tmo_cnt_q;
    logic [7:0] tmo_cnt_d;

    // Clear has priority so an ack or abort in the same cycle restarts from zero.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (clr) begin
            tmo_cnt_d = 8'd0;
        end else if (en) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign expired = (tmo_cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one variable-latency memory port.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned     STARVE_MAX = 4,
    parameter int unsigned     TIMEOUT    = 64,
    parameter logic [XLEN-1:0] DROP_DATA  = DROP_DATA_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_e      state;
    logic [3:0]      starve_cnt;
    logic            drop_f;

    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic            if_valid_q;
    logic [XLEN-1:0] if_rdata_q;
    logic            d_valid_q;
    logic [XLEN-1:0] d_rdata_q;
    logic            err_q;

    logic            d_req_eff;
    logic            fetch_win;
    logic            data_win;
    logic            busy;
    logic            tmo_expired;

    // A requester whose valid is up this cycle still holds req; don't grant it again.
    assign d_req_eff = bus.d_req & ~d_valid_q;
    assign fetch_win = bus.if_req & ~bus.if_flush & ~if_valid_q &
                       (~d_req_eff | (starve_cnt == 4'(STARVE_MAX)));
    assign data_win  = d_req_eff & ~fetch_win;
    assign busy      = (state != IDLE);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (~busy | bus.mem_ack | tmo_expired),
        .en      (busy),
        .expired (tmo_expired)
    );

    // Arbitration FSM with registered memory-port and completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= 4'd0;
            drop_f      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_valid_q   <= 1'b0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    drop_f <= 1'b0;
                    if (fetch_win) begin
                        state       <= BUSY_I;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        starve_cnt  <= 4'd0;
                    end else if (data_win) begin
                        state       <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                        if (bus.if_req && (starve_cnt != 4'(STARVE_MAX))) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if ((state == BUSY_I) && bus.if_flush) begin
                        drop_f <= 1'b1;
                    end
                    // Ack beats a same-cycle timeout.
                    if (bus.mem_ack || tmo_expired) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                        drop_f    <= 1'b0;
                        if (!bus.mem_ack) begin
                            err_q <= 1'b1;
                        end
                        if (state == BUSY_I) begin
                            if (!(drop_f || bus.if_flush)) begin
                                if_valid_q <= 1'b1;
                                if_rdata_q <= bus.mem_ack ? bus.mem_rdata : DROP_DATA;
                            end
                        end else begin
                            d_valid_q <= 1'b1;
                            if (!bus.mem_ack) begin
                                d_rdata_q <= DROP_DATA;
                            end else if (mem_we_q) begin
                                d_rdata_q <= '0;
                            end else begin
                                d_rdata_q <= bus.mem_rdata;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.d_valid     = d_valid_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.err_timeout = err_q;

    // Stalls follow the requests combinationally and release in the valid cycle.
    assign bus.stall_f = bus.if_req & ~if_valid_q;
    assign bus.stall_m = bus.d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter with a simple variable-latency memory model.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    localparam int unsigned SMAX = 4;
    localparam int unsigned TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .STARVE_MAX (SMAX),
        .TIMEOUT    (TMO),
        .DROP_DATA  (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } xact_t;

    xact_t sb_q[$];

    int n_checks = 0;
    int n_bad    = 0;

    bit ack_en      = 1'b1;
    int ack_delay   = 1;
    bit stray_ack   = 1'b0;
    bit flush_reg   = 1'b0;
    bit flush_on_dv = 1'b0;

    assign bus.if_flush = flush_reg | (flush_on_dv & bus.d_valid);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_x(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [31:0] rdata);
        xact_t x;
        x.addr  = addr;
        x.we    = we;
        x.wdata = wdata;
        x.rdata = rdata;
        sb_q.push_back(x);
    endtask

    // Returns the negedge index (1-based) at which the chosen valid was seen, or -1.
    task automatic wait_valid(input bit fetch, input int max, output int k);
        k = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (fetch ? bus.if_valid : bus.d_valid) begin
                k = i;
                return;
            end
        end
    endtask

    // Memory model: checks each new request against the scoreboard, acks after ack_delay.
    initial begin : mem_model
        int    wait_cnt;
        bit    served;
        xact_t cur;
        wait_cnt = 0;
        served = 1'b0;
        cur.rdata = 32'h0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (stray_ack) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = 32'hBAD0_BAD0;
                stray_ack = 1'b0;
            end else if (bus.mem_req === 1'b1 && !served) begin
                if (wait_cnt == 0) begin
                    if (sb_q.size() == 0) begin
                        check_eq("sb_underflow", sb_q.size(), 1);
                    end else begin
                        cur = sb_q.pop_front();
                        check_eq("mem_addr", bus.mem_addr, cur.addr);
                        check_eq("mem_we", 32'(bus.mem_we), 32'(cur.we));
                        if (cur.we) check_eq("mem_wdata", bus.mem_wdata, cur.wdata);
                    end
                end
                wait_cnt++;
                if (ack_en && wait_cnt >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = cur.rdata;
                    served = 1'b1;
                end
            end else if (bus.mem_req !== 1'b1) begin
                served = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin : guard
        #400000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        int k;
        int nd;
        bus.if_req = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h0;
        bus.d_wdata = 32'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_mem_req", 32'(bus.mem_req), 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_if_valid", 32'(bus.if_valid), 0);
        check_eq("rst_d_valid", 32'(bus.d_valid), 0);
        check_eq("rst_err", 32'(bus.err_timeout), 0);
        check_eq("rst_stall_f", 32'(bus.stall_f), 0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch only, ack in the third request cycle
        ack_delay = 3;
        push_x(32'h100, 1'b0, 32'h0, 32'h0050_0093);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h100;
        #1 check_eq("fo_stall_f_on", 32'(bus.stall_f), 1);
        wait_valid(1'b1, 20, k);
        check_eq("fo_latency", k, 4);
        check_eq("fo_rdata", bus.if_rdata, 32'h0050_0093);
        check_eq("fo_stall_f_off", 32'(bus.stall_f), 0);
        bus.if_req = 1'b0;
        @(negedge clk);
        check_eq("fo_pulse", 32'(bus.if_valid), 0);

        // Simultaneous fetch and load: data first, fetch in the d_valid cycle
        ack_delay = 1;
        push_x(32'h2000, 1'b0, 32'h0, 32'hDEAD_BEEF);
        push_x(32'h104, 1'b0, 32'h0, 32'h0000_0013);
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h2000;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h104;
        #1 check_eq("sim_stall_m_on", 32'(bus.stall_m), 1);
        wait_valid(1'b0, 20, k);
        check_eq("sim_d_latency", k, 2);
        check_eq("sim_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        wait_valid(1'b1, 20, k);
        check_eq("sim_i_latency", k, 2);
        check_eq("sim_i_rdata", bus.if_rdata, 32'h0000_0013);
        bus.if_req = 1'b0;
        @(negedge clk);

        // Starvation: flush in each d_valid cycle keeps fetch out until the guard fires
        flush_on_dv = 1'b1;
        ack_delay = 1;
        for (int i = 0; i < 4; i++) push_x(32'h4000, 1'b0, 32'h0, 32'h1000 + 32'(i));
        push_x(32'h300, 1'b0, 32'h0, 32'h0000_0033);
        push_x(32'h4000, 1'b0, 32'h0, 32'h0000_1004);
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h4000;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h300;
        nd = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.d_valid) begin
                check_eq("st_d_rdata", bus.d_rdata, 32'h1000 + 32'(nd));
                nd++;
                if (nd == 5) bus.d_req = 1'b0;
            end
            if (bus.if_valid) begin
                check_eq("st_order", nd, 4);
                check_eq("st_i_rdata", bus.if_rdata, 32'h0000_0033);
                check_eq("st_cnt_clr", 32'(dut.starve_cnt), 0);
                bus.if_req = 1'b0;
            end
            if (nd == 5) break;
        end
        check_eq("st_data_count", nd, 5);
        flush_on_dv = 1'b0;
        @(negedge clk);

        // Flush one cycle after BUSY_I entry; next fetch proceeds normally
        ack_delay = 4;
        push_x(32'h400, 1'b0, 32'h0, 32'h0000_4444);
        push_x(32'h200, 1'b0, 32'h0, 32'h0000_2222);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h400;
        @(negedge clk);
        check_eq("fl_busy", 32'(bus.mem_req), 1);
        @(negedge clk);
        flush_reg = 1'b1;
        @(negedge clk);
        flush_reg = 1'b0;
        bus.if_addr = 32'h200;
        wait_valid(1'b1, 30, k);
        check_eq("fl_next_latency", k, 7);
        check_eq("fl_next_rdata", bus.if_rdata, 32'h0000_2222);
        bus.if_req = 1'b0;
        @(negedge clk);

        // Timeout on a store with no ack
        ack_en = 1'b0;
        push_x(32'h3000, 1'b1, 32'hCAFE_F00D, 32'h0);
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h3000;
        bus.d_wdata = 32'hCAFE_F00D;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mem_req) nd++;
            if (bus.d_valid) break;
        end
        check_eq("to_req_cycles", nd, TMO);
        check_eq("to_valid", 32'(bus.d_valid), 1);
        check_eq("to_rdata", bus.d_rdata, 32'h0);
        check_eq("to_err", 32'(bus.err_timeout), 1);
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("to_stray_idle", {29'd0, bus.mem_req, bus.if_valid, bus.d_valid}, 0);
        end
        check_eq("to_err_held", 32'(bus.err_timeout), 1);
        check_eq("to_state", 32'(dut.state), 32'(IDLE));

        // Reset in BUSY_D, pending fetch granted on the first clock after release
        push_x(32'h5000, 1'b0, 32'h0, 32'h0000_0055);
        bus.d_req = 1'b1;
        bus.d_addr = 32'h5000;
        @(negedge clk);
        check_eq("rm_busy", 32'(bus.mem_req), 1);
        @(negedge clk);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h600;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rm_mem_req", 32'(bus.mem_req), 0);
        check_eq("rm_mem_addr", bus.mem_addr, 0);
        check_eq("rm_err", 32'(bus.err_timeout), 0);
        check_eq("rm_state", 32'(dut.state), 32'(IDLE));
        bus.d_req = 1'b0;
        push_x(32'h600, 1'b0, 32'h0, 32'h0000_0066);
        ack_en = 1'b1;
        ack_delay = 1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rm_regrant", 32'(bus.mem_req), 1);
        check_eq("rm_regrant_addr", bus.mem_addr, 32'h600);
        wait_valid(1'b1, 10, k);
        check_eq("rm_i_latency", k, 1);
        check_eq("rm_i_rdata", bus.if_rdata, 32'h0000_0066);
        bus.if_req = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline.
- Serialises requests through an FSM and returns read data to the winning requester.
- Generates stall_f/stall_m for the pipeline.
- Adds a starvation guard for fetch and a watchdog timeout on the memory port.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while fetch waits before fetch is forced to win (1..15).
- TIMEOUT, 64: busy cycles without mem_ack before the access is aborted (2..255).
- DROP_DATA, 32'h0000_0000: rdata returned on a timed-out access.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  32  fetch address, stable while if_req
- if_flush  in  1  cancel outstanding/pending fetch (branch taken)
- if_valid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  32  fetched instruction
- stall_f  out  1  fetch/decode stall
- d_req  in  1  data request, level, held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_valid  out  1  one-cycle completion pulse
- d_rdata  out  32  load data (0 for stores)
- stall_m  out  1  stall of memory stage and all earlier stages
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  one-cycle completion from memory
- mem_rdata  in  32  read data, valid with mem_ack
- err_timeout  out  1  sticky timeout flag, cleared only by rst

Behaviour:
- **Reset (async, immediate):**
  - State IDLE.
  - mem_req, mem_we, if_valid, d_valid and err_timeout = 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata = 0.
  - starve_cnt, tmo_cnt and drop_f = 0.
  - Reset mid-access abandons the access; a late mem_ack after reset is ignored in IDLE.
- **FSM states:** IDLE, BUSY_I, BUSY_D. All mem_* outputs are registered.
- **Arbitration (IDLE):**
  - fetch_win = if_req & ~if_flush & ~mask_i & (~d_req_eff | starve_cnt == STARVE_MAX).
  - Otherwise d_req_eff (d_req & ~mask_d) wins.
  - The winner's address/data/we are latched into mem_*, mem_req goes to 1 next cycle, and the state goes to BUSY_I or BUSY_D.
  - With no eligible request, stay in IDLE.
- **Grant masks:** mask_i / mask_d = the matching valid is high this cycle. This prevents re-granting a requester that has not yet dropped its req in its completion cycle.
- **Starvation counter:**
  - Increments (saturating at STARVE_MAX) on each data grant made while if_req is high.
  - Clears on each fetch grant.
- **BUSY_x:**
  - mem_req stays 1; tmo_cnt increments each cycle.
  - On mem_ack: mem_req drops to 0, tmo_cnt clears and the state returns to IDLE.
  - The matching valid pulses the next cycle, with rdata = mem_rdata registered (d_rdata = 0 if d_we).
  - Latency: grant at cycle N, mem_req from N+1, ack at M, valid at M+1. IDLE at M+1 may grant the other requester in that same cycle.
- **Timeout:**
  - When tmo_cnt reaches TIMEOUT-1 without ack: mem_req drops to 0, err_timeout is set, and the valid pulses with rdata = DROP_DATA.
  - A later stray mem_ack in IDLE is ignored.
- **Flush:**
  - if_flush in BUSY_I sets drop_f. On completion (ack or timeout) if_valid is suppressed, and drop_f clears on return to IDLE.
  - if_flush in IDLE blocks the fetch grant that cycle.
  - if_flush has no effect on BUSY_D.
- **Stalls:** combinational. stall_f = if_req & ~if_valid; stall_m = d_req & ~d_valid.
- **Simultaneous events:**
  - mem_ack and timeout in the same cycle: the ack wins and err_timeout is not set.
  - if_flush and mem_ack in BUSY_I in the same cycle: the fetch is dropped.

Decomposition:
- Shared package arb_pkg: state encoding (IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2), XLEN = 32, DROP_DATA default.
- One natural sub-module, arb_watchdog: tmo_cnt with a clear/enable input and an expired output, parameterised by TIMEOUT.

Test Plan:
- **Fetch only:** if_req = 1, if_addr = 0x100, mem_ack 3 cycles after mem_req, mem_rdata = 0x00500093 → mem_addr = 0x100, if_valid for 1 cycle with if_rdata = 0x00500093, stall_f high until then.
- **Simultaneous requests:** if_req and d_req (load 0x2000) in the same cycle → data served first; fetch granted in the d_valid cycle; 1-cycle-ack memory gives d_valid at cycle 3 and if_valid at cycle 5.
- **Starvation:** d_req held continuously with STARVE_MAX = 4 and fetch pending → after 4 data grants the 5th grant is fetch; starve_cnt returns to 0.
- **Flush mid-fetch:** if_flush pulsed 1 cycle after BUSY_I entry, ack later → no if_valid; the next fetch (addr 0x200) is granted normally.
- **Timeout:** d_req store to 0x3000, mem_ack never asserted, TIMEOUT = 8 → mem_req high exactly 8 cycles, d_valid with d_rdata = 0, err_timeout = 1 held; a late mem_ack is ignored.
- **Reset mid-access:** rst asserted in BUSY_D → mem_req = 0 immediately, IDLE, all outputs 0; after release, a pending if_req is granted on the first clock.
